avr_cpu_stack_ctrl: RTL and testbench

Parametrised hardware return stack for the AVR CPU core. It is the successor to the fixed 9-bit hardware stack and sits between the program-counter logic and the call/return decode. It adds configurable width and depth, separate data-in and data-out ports, and a registered top-of-stack output. It reports full/empty, fill count and sticky overflow/underflow errors, and offers a selectable full-stack policy: reject the push, or wrap and discard the oldest entry (tiny-core behaviour).

---
 rtl/avr_cpu_stack_ctrl.sv | 115 +++++++++++
 tb/tb_avr_cpu_stack_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/avr_cpu_stack_ctrl.sv
// avr_cpu_stack_ctrl: parametrised hardware return stack.
// Circular buffer of DEPTH entries with a registered top-of-stack output,
// fill count, full/empty decode and sticky overflow/underflow flags.
// WRAP selects the full-stack policy: reject the push, or overwrite the oldest entry.
module avr_cpu_stack_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int WRAP  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    input  logic                         clear_err,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    tp;
    logic [PW-1:0]    tp_inc;
    logic [PW-1:0]    tp_dec;
    logic [PW-1:0]    tp_nxt;
    logic [PW-1:0]    wr_addr;
    logic             wr_en;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             ovf_set;
    logic             unf_set;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Neighbouring top-pointer values; the pointer wraps at DEPTH-1 so any DEPTH works.
    always_comb begin
        tp_inc = (tp == PW'(DEPTH - 1)) ? '0 : tp + 1'b1;
        tp_dec = (tp == '0) ? PW'(DEPTH - 1) : tp - 1'b1;
    end

    // Next-state decision from the pre-edge state; push+pop on an empty stack acts as a push.
    always_comb begin
        tp_nxt    = tp;
        count_nxt = count;
        dout_nxt  = dout;
        wr_en     = 1'b0;
        wr_addr   = tp;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (push && pop && !empty) begin
            // Replace the top entry in place; legal even when full.
            wr_en    = 1'b1;
            wr_addr  = tp;
            dout_nxt = din;
        end else if (push) begin
            if (!full) begin
                tp_nxt    = tp_inc;
                wr_en     = 1'b1;
                wr_addr   = tp_inc;
                count_nxt = count + 1'b1;
                dout_nxt  = din;
            end else begin
                ovf_set = 1'b1;
                if (WRAP != 0) begin
                    // The slot after the newest entry holds the oldest one, so it is overwritten.
                    tp_nxt   = tp_inc;
                    wr_en    = 1'b1;
                    wr_addr  = tp_inc;
                    dout_nxt = din;
                end
            end
        end else if (pop) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                tp_nxt    = tp_dec;
                count_nxt = count - 1'b1;
                dout_nxt  = (count == CW'(1)) ? '0 : mem[tp_dec];
            end
        end
    end

    // Storage array: never reset, contents are hidden while the stack is empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    // Control state, top-of-stack register and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp        <= '0;
            count     <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tp        <= tp_nxt;
            count     <= count_nxt;
            dout      <= dout_nxt;
            overflow  <= ovf_set | (overflow & ~clear_err);
            underflow <= unf_set | (underflow & ~clear_err);
        end
    end

endmodule

// File: tb/tb_avr_cpu_stack_ctrl.sv
// tb_avr_cpu_stack_ctrl: drives three stack instances (DEPTH 8 reject,
// DEPTH 4 reject, DEPTH 4 wrap) with identical stimulus. A behavioural
// model queues the expected post-edge outputs; they are popped and compared
// one cycle later.
module tb_avr_cpu_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic        pop;
    logic        clear_err;
    logic [15:0] din;

    logic [2:0][15:0] dout_w;
    logic [3:0]       cnt0;
    logic [2:0]       cnt1;
    logic [2:0]       cnt2;
    logic [2:0]       empty_w;
    logic [2:0]       full_w;
    logic [2:0]       ovf_w;
    logic [2:0]       unf_w;

    always #5 clk = ~clk;

    avr_cpu_stack_ctrl #(.WIDTH(16), .DEPTH(8), .WRAP(0)) u_d8 (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
        .clear_err(clear_err), .dout(dout_w[0]), .count(cnt0),
        .empty(empty_w[0]), .full(full_w[0]), .overflow(ovf_w[0]), .underflow(unf_w[0])
    );

    avr_cpu_stack_ctrl #(.WIDTH(16), .DEPTH(4), .WRAP(0)) u_rej (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
        .clear_err(clear_err), .dout(dout_w[1]), .count(cnt1),
        .empty(empty_w[1]), .full(full_w[1]), .overflow(ovf_w[1]), .underflow(unf_w[1])
    );

    avr_cpu_stack_ctrl #(.WIDTH(16), .DEPTH(4), .WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
        .clear_err(clear_err), .dout(dout_w[2]), .count(cnt2),
        .empty(empty_w[2]), .full(full_w[2]), .overflow(ovf_w[2]), .underflow(unf_w[2])
    );

    typedef struct {
        int d;
        int dout;
        int cnt;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: index 0 is the bottom, m_cnt-1 the top.
    int m_cnt [3];
    int m_stk [3][8];
    bit m_ovf [3];
    bit m_unf [3];

    function automatic int dep(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    function automatic int get_cnt(input int d);
        case (d)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = 0;
            m_ovf[d] = 1'b0;
            m_unf[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input bit pu, input bit po, input int dv, input bit clr);
        bit eo;
        bit eu;
        eo = 1'b0;
        eu = 1'b0;
        if (pu && po && m_cnt[d] > 0) begin
            m_stk[d][m_cnt[d]-1] = dv;
        end else if (pu) begin
            if (m_cnt[d] < dep(d)) begin
                m_stk[d][m_cnt[d]] = dv;
                m_cnt[d]++;
            end else begin
                eo = 1'b1;
                if (d == 2) begin
                    for (int i = 0; i < dep(d) - 1; i++) m_stk[d][i] = m_stk[d][i+1];
                    m_stk[d][dep(d)-1] = dv;
                end
            end
        end else if (po) begin
            if (m_cnt[d] == 0) eu = 1'b1;
            else m_cnt[d]--;
        end
        m_ovf[d] = eo | (m_ovf[d] & !clr);
        m_unf[d] = eu | (m_unf[d] & !clr);
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("%s_dout[%0d]", tag, d), int'(dout_w[d]), 0);
            check_eq($sformatf("%s_cnt[%0d]", tag, d), get_cnt(d), 0);
            check_eq($sformatf("%s_empty[%0d]", tag, d), int'(empty_w[d]), 1);
            check_eq($sformatf("%s_ovf[%0d]", tag, d), int'(ovf_w[d]), 0);
            check_eq($sformatf("%s_unf[%0d]", tag, d), int'(unf_w[d]), 0);
        end
    endtask

    // One clock of stimulus: predict, push expectations, clock, pop and compare.
    task automatic drive(input bit pu, input bit po, input int dv, input bit clr);
        exp_t e;
        push      = pu;
        pop       = po;
        din       = 16'(dv);
        clear_err = clr;
        for (int d = 0; d < 3; d++) begin
            model_step(d, pu, po, dv, clr);
            e.d    = d;
            e.cnt  = m_cnt[d];
            e.dout = (m_cnt[d] == 0) ? 0 : m_stk[d][m_cnt[d]-1];
            e.ovf  = m_ovf[d];
            e.unf  = m_unf[d];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            check_eq($sformatf("dout[%0d]", e.d), int'(dout_w[e.d]), e.dout);
            check_eq($sformatf("count[%0d]", e.d), get_cnt(e.d), e.cnt);
            check_eq($sformatf("empty[%0d]", e.d), int'(empty_w[e.d]), (e.cnt == 0) ? 1 : 0);
            check_eq($sformatf("full[%0d]", e.d), int'(full_w[e.d]), (e.cnt == dep(e.d)) ? 1 : 0);
            check_eq($sformatf("overflow[%0d]", e.d), int'(ovf_w[e.d]), int'(e.ovf));
            check_eq($sformatf("underflow[%0d]", e.d), int'(unf_w[e.d]), int'(e.unf));
        end
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
        din       = '0;
        model_reset();
        #12;
        check_reset("reset");
        rst_n = 1'b1;

        // Push 1..4, pop x4
        for (int i = 1; i <= 4; i++) drive(1, 0, i, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);

        // Underflow, clear colliding with new error, clear alone
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 1);

        // Fill past capacity: reject vs wrap on the DEPTH 4 instances
        for (int i = 10; i <= 15; i++) drive(1, 0, i, 0);
        check_eq("rej_top", int'(dout_w[1]), 13);
        check_eq("rej_full", int'(full_w[1]), 1);
        check_eq("wrap_top", int'(dout_w[2]), 15);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 0);
        drive(0, 0, 0, 1);

        // Replace-top and push+pop on empty
        drive(1, 0, 5, 0);
        drive(1, 0, 6, 0);
        drive(1, 1, 9, 0);
        check_eq("replace_top", int'(dout_w[0]), 9);
        drive(0, 1, 0, 0);
        check_eq("after_replace_pop", int'(dout_w[0]), 5);
        drive(0, 1, 0, 0);
        drive(1, 1, 7, 0);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);

        // Asynchronous reset between edges, then a push on the fresh stack
        for (int i = 1; i <= 3; i++) drive(1, 0, i + 20, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(1, 0, 42, 0);

        // Random traffic, full throughput
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 65535)), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
